// File: rtl/parity_pkg.sv
// Shared encodings, state type and default sizes for the parity stream generator/checker.
package parity_pkg;

  localparam int WIDTH_DEF     = 8;
  localparam int FRAME_LEN_DEF = 4;
  localparam int CNT_W_DEF     = 16;

  localparam logic MODE_GEN = 1'b0;
  localparam logic MODE_CHK = 1'b1;
  localparam logic PAR_EVEN = 1'b0;
  localparam logic PAR_ODD  = 1'b1;

  typedef enum logic {
    IDLE     = 1'b0,
    IN_FRAME = 1'b1
  } state_t;

endpackage

// File: rtl/parity_word.sv
// Combinational XOR-reduce of one word, inverted when odd parity is selected.
module parity_word import parity_pkg::*; #(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic [WIDTH-1:0] i_data,
  input  logic             i_odd,
  output logic             o_par
);

  assign o_par = (^i_data) ^ (i_odd == PAR_ODD);

endmodule

// File: rtl/parity_stream_gen_chk.sv
// Pipelined parity generator/checker on a valid/ready stream with frame tracking.
// Define PARITY_LRC_EN to build the per-frame column-parity accumulator (frame_par).
module parity_stream_gen_chk import parity_pkg::*; #(
  parameter int WIDTH     = WIDTH_DEF,
  parameter int FRAME_LEN = FRAME_LEN_DEF,
  parameter int CNT_W     = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_par,
  input  logic             mode_chk,
  input  logic             odd_sel,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             out_par,
  output logic             out_err,
  output logic             frame_last,
  output logic [WIDTH-1:0] frame_par,
  output logic [CNT_W-1:0] err_count
);

  localparam int IDX_W = (FRAME_LEN > 1) ? $clog2(FRAME_LEN) : 1;

  state_t           r_state;
  logic [IDX_W-1:0] r_idx;
  logic             r_mode_chk_f;
  logic             r_odd_f;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_data;
  logic             r_out_par;
  logic             r_out_err;
  logic             r_frame_last;
  logic [CNT_W-1:0] r_err_count;

  logic             w_in_ready;
  logic             w_accept;
  logic             w_first;
  logic             w_last;
  logic             w_mode_chk;
  logic             w_odd;
  logic             w_par;

  assign w_in_ready = !r_out_valid || out_ready;
  assign w_accept   = in_valid && w_in_ready;
  assign w_first    = (r_state == IDLE);
  assign w_last     = (r_idx == IDX_W'(FRAME_LEN - 1));

  // Word 0 uses the live mode inputs; later words use the frame-latched copy.
  assign w_mode_chk = w_first ? mode_chk : r_mode_chk_f;
  assign w_odd      = w_first ? odd_sel  : r_odd_f;

  parity_word #(.WIDTH(WIDTH)) u_par (
    .i_data (in_data),
    .i_odd  (w_odd),
    .o_par  (w_par)
  );

  // Frame FSM: word index, state and mode latch.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= IDLE;
      r_idx        <= '0;
      r_mode_chk_f <= MODE_GEN;
      r_odd_f      <= PAR_EVEN;
    end else if (w_accept) begin
      if (w_first) begin
        r_mode_chk_f <= mode_chk;
        r_odd_f      <= odd_sel;
      end
      if (w_last) begin
        r_idx   <= '0;
        r_state <= IDLE;
      end else begin
        r_idx   <= r_idx + 1'b1;
        r_state <= IN_FRAME;
      end
    end
  end

  // One-deep output register; a pop and a new accept in the same cycle reload without a bubble.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_out_valid  <= 1'b0;
      r_out_data   <= '0;
      r_out_par    <= 1'b0;
      r_out_err    <= 1'b0;
      r_frame_last <= 1'b0;
    end else if (w_accept) begin
      r_out_valid  <= 1'b1;
      r_out_data   <= in_data;
      r_out_par    <= w_par;
      r_out_err    <= (w_mode_chk == MODE_CHK) && (w_par != in_par);
      r_frame_last <= w_last;
    end else if (out_ready) begin
      r_out_valid  <= 1'b0;
    end
  end

  // Errors are counted as the sink consumes them, saturating at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_err_count <= '0;
    end else if (r_out_valid && out_ready && r_out_err && !(&r_err_count)) begin
      r_err_count <= r_err_count + 1'b1;
    end
  end

`ifdef PARITY_LRC_EN
  logic [WIDTH-1:0] r_acc;
  logic [WIDTH-1:0] r_frame_par;
  logic [WIDTH-1:0] w_acc_nxt;

  assign w_acc_nxt = r_acc ^ in_data;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_acc       <= '0;
      r_frame_par <= '0;
    end else if (w_accept) begin
      r_acc       <= w_last ? '0 : w_acc_nxt;
      r_frame_par <= w_acc_nxt ^ {WIDTH{w_odd == PAR_ODD}};
    end
  end

  assign frame_par = r_frame_par;
`else
  assign frame_par = '0;
`endif

  assign in_ready   = w_in_ready;
  assign out_valid  = r_out_valid;
  assign out_data   = r_out_data;
  assign out_par    = r_out_par;
  assign out_err    = r_out_err;
  assign frame_last = r_frame_last;
  assign err_count  = r_err_count;

endmodule

// File: tb/tb_parity_stream_gen_chk.sv
// Directed table-driven bench for parity_stream_gen_chk (WIDTH=8, FRAME_LEN=4, CNT_W=2).
module tb_parity_stream_gen_chk;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] in_data;
  logic       in_par;
  logic       mode_chk;
  logic       odd_sel;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] out_data;
  logic       out_par;
  logic       out_err;
  logic       frame_last;
  logic [7:0] frame_par;
  logic [1:0] err_count;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  parity_stream_gen_chk #(.WIDTH(8), .FRAME_LEN(4), .CNT_W(2)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .in_par     (in_par),
    .mode_chk   (mode_chk),
    .odd_sel    (odd_sel),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_data   (out_data),
    .out_par    (out_par),
    .out_err    (out_err),
    .frame_last (frame_last),
    .frame_par  (frame_par),
    .err_count  (err_count)
  );

  typedef struct {
    logic [7:0] data;
    logic       pin;
    logic       chk;
    logic       odd;
    logic       e_par;
    logic       e_err;
    logic       e_last;
    logic [7:0] e_fpar;
  } vec_t;

  vec_t vecs[20];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [7:0] d, input logic p, input logic c, input logic o);
    in_valid = v;
    in_data  = d;
    in_par   = p;
    mode_chk = c;
    odd_sel  = o;
  endtask

  task automatic pulse_reset();
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    rst = 1'b1;
    #2;
    check("rst out_valid", 32'(out_valid), 32'd0);
    check("rst err_count", 32'(err_count), 32'd0);
    check("rst frame_last", 32'(frame_last), 32'd0);
    rst = 1'b0;
  endtask

  function automatic logic [7:0] exp_fp(input logic [7:0] v);
`ifdef PARITY_LRC_EN
    return v;
`else
    return (v == v) ? 8'h00 : 8'h00;
`endif
  endfunction

  initial begin
    // frame A: generate, even
    vecs[0]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[1]  = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[2]  = '{8'h03, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[3]  = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'hFD};
    // frame B: generate, odd
    vecs[4]  = '{8'h07, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[5]  = '{8'h00, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[6]  = '{8'h0F, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[7]  = '{8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b1, 8'hF6};
    // frame C: check, even
    vecs[8]  = '{8'h01, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[9]  = '{8'h03, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00};
    vecs[10] = '{8'h05, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[11] = '{8'hF0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 8'hF7};
    // frame D: mode_chk/odd_sel toggled at word 2, latched generate-even stays
    vecs[12] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[13] = '{8'h01, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[14] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[15] = '{8'h01, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h00};
    // frame E: odd latched at word 0, toggled back mid-frame
    vecs[16] = '{8'h01, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'h00};
    vecs[17] = '{8'h03, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[18] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'h00};
    vecs[19] = '{8'h80, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h82};

    rst = 1'b1;
    out_ready = 1'b1;
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    #12;
    check("reset out_valid", 32'(out_valid), 32'd0);
    check("reset out_data", 32'(out_data), 32'd0);
    check("reset out_par", 32'(out_par), 32'd0);
    check("reset out_err", 32'(out_err), 32'd0);
    check("reset frame_par", 32'(frame_par), 32'd0);
    check("reset err_count", 32'(err_count), 32'd0);
    rst = 1'b0;
    tick();
    check("reset in_ready", 32'(in_ready), 32'd1);

    for (int i = 0; i < 20; i++) begin
      drive(1'b1, vecs[i].data, vecs[i].pin, vecs[i].chk, vecs[i].odd);
      tick();
      check($sformatf("v%0d out_valid", i), 32'(out_valid), 32'd1);
      check($sformatf("v%0d out_data", i), 32'(out_data), 32'(vecs[i].data));
      check($sformatf("v%0d out_par", i), 32'(out_par), 32'(vecs[i].e_par));
      check($sformatf("v%0d out_err", i), 32'(out_err), 32'(vecs[i].e_err));
      check($sformatf("v%0d frame_last", i), 32'(frame_last), 32'(vecs[i].e_last));
      if (vecs[i].e_last)
        check($sformatf("v%0d frame_par", i), 32'(frame_par), 32'(exp_fp(vecs[i].e_fpar)));
    end
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    check("drain out_valid", 32'(out_valid), 32'd0);
    check("err_count after check frame", 32'(err_count), 32'd2);

    // backpressure: AA held while BB waits three cycles
    out_ready = 1'b0;
    drive(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
    tick();
    check("bp first accept", 32'(out_data), 32'hAA);
    drive(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
    for (int c = 0; c < 3; c++) begin
      check($sformatf("bp%0d in_ready", c), 32'(in_ready), 32'd0);
      tick();
      check($sformatf("bp%0d out_valid", c), 32'(out_valid), 32'd1);
      check($sformatf("bp%0d out_data hold", c), 32'(out_data), 32'hAA);
      check($sformatf("bp%0d out_par hold", c), 32'(out_par), 32'd0);
    end
    out_ready = 1'b1;
    tick();
    check("bp release data", 32'(out_data), 32'hBB);
    check("bp release valid", 32'(out_valid), 32'd1);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    check("bp no duplicate", 32'(out_valid), 32'd0);

    // reset at word 2 of a check frame, then saturation with CNT_W=2
    pulse_reset();
    for (int w = 0; w < 3; w++) begin
      drive(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
      tick();
    end
    check("pre-reset err_count", 32'(err_count), 32'd2);
    pulse_reset();
    for (int w = 0; w < 6; w++) begin
      drive(1'b1, 8'h01, 1'b0, 1'b1, 1'b0);
      tick();
      check($sformatf("sat%0d out_err", w), 32'(out_err), 32'd1);
      check($sformatf("sat%0d frame_last", w), 32'(frame_last), (w == 3) ? 32'd1 : 32'd0);
      if (w == 3) check("sat err_count at 3 pops", 32'(err_count), 32'd3);
    end
    check("sat err_count at 5 pops", 32'(err_count), 32'd3);
    drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    tick();
    check("sat err_count final", 32'(err_count), 32'd3);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/parity_stream_gen_chk.md
# parity_stream_gen_chk

Parametrised, pipelined parity generator/checker for a stream of WIDTH-bit words grouped into frames of FRAME_LEN words. Each accepted word gets an even or odd parity bit. In check mode, the block compares that parity bit against a received bit and counts mismatches. Optionally, it also accumulates a longitudinal (column) parity word over each frame. It sits between a word source and a sink on a valid/ready stream and replaces the fixed three-input combinational even-parity block.

## Interface
Parameters:
- WIDTH, 8: data word width (≥1)
- FRAME_LEN, 4: words per frame (≥1)
- CNT_W, 16: error counter width

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- in_valid  input  1  source word valid
- in_ready  output  1  block can accept a word
- in_data  input  WIDTH  data word
- in_par  input  1  received parity bit (used only in check mode)
- mode_chk  input  1  0 = generate, 1 = check
- odd_sel  input  1  0 = even parity, 1 = odd parity
- out_valid  output  1  output beat valid
- out_ready  input  1  sink accepts beat
- out_data  output  WIDTH  registered copy of in_data
- out_par  output  1  computed parity bit
- out_err  output  1  check mode: out_par != captured in_par; generate mode: 0
- frame_last  output  1  beat is the last word of its frame
- frame_par  output  WIDTH  column parity of the frame, valid when frame_last
- err_count  output  CNT_W  saturating mismatch count

## Operation
- Accept: a word is accepted when in_valid && in_ready. in_ready = !out_valid || out_ready (one-deep register stage, no combinational in→out data path).
- Parity: out_par = ^in_data ^ odd_sel_f, where odd_sel_f is the frame-latched odd_sel.
- Mode latching: mode_chk and odd_sel are sampled only on the first word of a frame (word index 0). They are held for the rest of the frame, so changes mid-frame take effect at the next frame.
- Word index: counts 0..FRAME_LEN-1 per accepted word and wraps to 0 after FRAME_LEN-1. When FRAME_LEN=1, every word is both first and last.
- States: IDLE (index 0, no frame open) and IN_FRAME (index 1..FRAME_LEN-1).
  - IDLE→IN_FRAME: on accept when FRAME_LEN>1.
  - IN_FRAME→IDLE: on accept of word FRAME_LEN-1.
- Check: out_err = mode_chk_f && (out_par != in_par captured with the word).
- Error counter: err_count increments by 1 when an out_err beat is accepted by the sink (out_valid && out_ready && out_err). It saturates at all-ones and never wraps.
- Column parity:
  - An accumulator XORs each accepted word.
  - frame_par = accumulated XOR of all words in the frame, with each bit inverted if odd_sel_f = 1.
  - The accumulator clears to 0 when the last word is accepted, so the next frame starts clean.
- Output hold: while out_valid && !out_ready, all out_* outputs, frame_last and frame_par hold stable.

## Timing
- Latency: a word accepted at edge N appears on out_* from edge N, visible in cycle N+1, together with its parity and error bit.
- Throughput: one word per cycle while out_ready = 1.
- Reset values (asynchronous, take effect immediately):
  - out_valid = 0, out_data = 0, out_par = 0, out_err = 0
  - frame_last = 0, frame_par = 0, err_count = 0
  - word index = 0, state = IDLE, accumulator = 0
  - in_ready = 1 after reset releases
- Reset mid-frame: the partial frame is discarded, and the next accepted word is word 0.
- Simultaneous output pop and input accept in the same cycle: the output register is reloaded with no bubble.
- Saturation: an error beat with err_count = all-ones leaves the count unchanged.

## Configuration
- PARITY_LRC_EN defined: the column-parity accumulator is built, and frame_par behaves as described.
- PARITY_LRC_EN undefined:
  - No accumulator logic is built, and frame_par is tied to 0.
  - frame_last, the word index and all per-word behaviour are unchanged.

## Structure
- Shared package parity_pkg:
  - mode encoding constants: MODE_GEN = 0, MODE_CHK = 1, PAR_EVEN = 0, PAR_ODD = 1
  - state enum: IDLE, IN_FRAME
  - the default values of WIDTH, FRAME_LEN and CNT_W
- Sub-module parity_word: parametrised combinational XOR-reduce plus odd_sel inversion (the generalised even_pg), instantiated once for out_par.
- Top-level block contents: the handshake register, word index, mode latch, accumulator and counter.

## Test plan
- Generate, even, WIDTH=8: words 8'h00, 8'h01, 8'h03, 8'hFF → out_par = 0, 1, 0, 0, each one cycle after accept; out_err = 0.
- Generate, odd: word 8'h07 → out_par = 0; word 8'h00 → out_par = 1.
- Check, even, FRAME_LEN=4: words 8'h01/in_par=1, 8'h03/in_par=1, 8'h05/in_par=0, 8'hF0/in_par=1 → out_err = 0, 1, 0, 1; err_count = 2; frame_last on the 4th beat; with PARITY_LRC_EN, frame_par = 8'hF7.
- Backpressure: hold out_ready = 0 for 3 cycles with in_valid = 1 → in_ready = 0, outputs stable, no word lost or duplicated after release.
- Mode change mid-frame (odd_sel toggled at word 2) → parity uses the latched value until the next frame's word 0.
- Reset at word 2 of a frame; CNT_W=2 saturation: 5 error beats → err_count = 3. After reset, the next word is treated as word 0, and frame_last falls on the 4th word after reset.
